// File: rtl/fifo_word_unpacker_if.sv
// Word-in / byte-out stream bundle for fifo_word_unpacker.
interface fifo_word_unpacker_if;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned BYTE_W = 8;

   logic              in_valid;
   logic [WORD_W-1:0] in_data;
   logic              byte_valid;
   logic [BYTE_W-1:0] byte_data;
   logic              byte_last;
   logic              byte_ready;

   // Stream owner side: produces words, consumes bytes.
   modport master (
      output in_valid,
      output in_data,
      output byte_ready,
      input  byte_valid,
      input  byte_data,
      input  byte_last
   );

   // Unpacker side: consumes words, produces bytes.
   modport slave (
      input  in_valid,
      input  in_data,
      input  byte_ready,
      output byte_valid,
      output byte_data,
      output byte_last
   );
endinterface

// File: rtl/fifo_word_unpacker.sv
// Buffers 32-bit words from an unstallable source and emits them LSB-first
// as a byte stream with valid/ready handshake, dropping words when full.
module fifo_word_unpacker #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                    fifo_clk,
   input  logic                    fifo_rst_n,
   fifo_word_unpacker_if.slave     bus,
   output logic [$clog2(DEPTH):0]  buf_count,
   output logic                    buf_full,
   output logic                    overflow,
   input  logic                    ovf_clr,
   output logic [7:0]              drop_cnt
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned IDX_W  = 2;
   localparam int unsigned DROP_W = 8;

   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(3);
   localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t              state_q, state_nxt;
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_nxt;
   logic [IDX_W-1:0]    idx_q, idx_nxt;
   logic [CNT_W-1:0]    count_q, count_nxt;
   logic                full_q, full_nxt;
   logic                byte_valid_q, byte_valid_nxt;
   logic [BYTE_W-1:0]   byte_data_q, byte_data_nxt;
   logic                byte_last_q, byte_last_nxt;
   logic                ovf_q, ovf_nxt;
   logic [DROP_W-1:0]   drop_q, drop_nxt;
   logic [WORD_W-1:0]   mem [DEPTH];

   logic                accept;
   logic                drop;
   logic                xfer;
   logic                pop;
   logic                empty_after_pop;
   logic [WORD_W-1:0]   word_nxt;

   // Edge events: word accept/drop against the pre-update count, byte transfer and word pop.
   always_comb begin
      accept          = bus.in_valid && (count_q != CNT_FULL);
      drop            = bus.in_valid && (count_q == CNT_FULL);
      xfer            = byte_valid_q && bus.byte_ready;
      pop             = xfer && (idx_q == IDX_LAST);
      empty_after_pop = (count_q == CNT_W'(pop));
   end

   // Next-state, pointer, occupancy and presented-byte logic.
   always_comb begin
      state_nxt      = state_q;
      idx_nxt        = idx_q;
      rd_ptr_nxt     = rd_ptr_q;
      count_nxt      = count_q;
      word_nxt       = '0;
      byte_valid_nxt = 1'b0;
      byte_data_nxt  = '0;
      byte_last_nxt  = 1'b0;

      if (accept && !pop) begin
         count_nxt = count_q + CNT_W'(1);
      end else if (pop && !accept) begin
         count_nxt = count_q - CNT_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (xfer) begin
               idx_nxt = idx_q + IDX_W'(1);
            end
            if (pop) begin
               rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
               if (count_nxt == '0) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      full_nxt = (count_nxt == CNT_FULL);

      // A word landing in an otherwise empty buffer is bypassed, since memory is written on this same edge.
      word_nxt       = (accept && empty_after_pop) ? bus.in_data : mem[rd_ptr_nxt];
      byte_valid_nxt = (state_nxt == SEND);
      if (byte_valid_nxt) begin
         byte_data_nxt = word_nxt[{idx_nxt, 3'b000} +: BYTE_W];
         byte_last_nxt = (idx_nxt == IDX_LAST);
      end
   end

   // Sticky overflow and saturating drop counter; a drop beats a same-edge clear.
   always_comb begin
      ovf_nxt  = ovf_q;
      drop_nxt = drop_q;
      if (drop) begin
         ovf_nxt  = 1'b1;
         drop_nxt = ovf_clr ? DROP_W'(1)
                            : ((drop_q == DROP_MAX) ? drop_q : drop_q + DROP_W'(1));
      end else if (ovf_clr) begin
         ovf_nxt  = 1'b0;
         drop_nxt = '0;
      end
   end

   // FSM state register.
   always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
      if (!fifo_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Pointers, index, occupancy, status and registered byte outputs.
   always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
      if (!fifo_rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         idx_q        <= '0;
         count_q      <= '0;
         full_q       <= 1'b0;
         byte_valid_q <= 1'b0;
         byte_data_q  <= '0;
         byte_last_q  <= 1'b0;
         ovf_q        <= 1'b0;
         drop_q       <= '0;
      end else begin
         if (accept) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         rd_ptr_q     <= rd_ptr_nxt;
         idx_q        <= idx_nxt;
         count_q      <= count_nxt;
         full_q       <= full_nxt;
         byte_valid_q <= byte_valid_nxt;
         byte_data_q  <= byte_data_nxt;
         byte_last_q  <= byte_last_nxt;
         ovf_q        <= ovf_nxt;
         drop_q       <= drop_nxt;
      end
   end

   // Word storage; not reset, only read once written.
   always_ff @(posedge fifo_clk) begin
      if (accept) begin
         mem[wr_ptr_q] <= bus.in_data;
      end
   end

   assign bus.byte_valid = byte_valid_q;
   assign bus.byte_data  = byte_data_q;
   assign bus.byte_last  = byte_last_q;
   assign buf_count      = count_q;
   assign buf_full       = full_q;
   assign overflow       = ovf_q;
   assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Scoreboard bench for fifo_word_unpacker: queue-level reference model,
// directed scenarios plus randomized traffic.
module tb_fifo_word_unpacker;

   localparam int unsigned DEPTH = 4;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_byte_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ovf_clr;
   logic [2:0]  buf_count;
   logic        buf_full;
   logic        overflow;
   logic [7:0]  drop_cnt;

   fifo_word_unpacker_if bus ();

   fifo_word_unpacker #(.DEPTH(DEPTH)) dut (
      .fifo_clk   (clk),
      .fifo_rst_n (rst_n),
      .bus        (bus.slave),
      .buf_count  (buf_count),
      .buf_full   (buf_full),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   int        checks   = 0;
   int        failures = 0;

   // Reference model: words held, bytes already sent from the head word, flags.
   int        mdl_held = 0;
   int        mdl_sent = 0;
   int        mdl_ovf  = 0;
   int        mdl_drop = 0;
   exp_byte_t exp_q[$];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic void model_reset();
      mdl_held = 0;
      mdl_sent = 0;
      mdl_ovf  = 0;
      mdl_drop = 0;
      exp_q.delete();
   endfunction

   function automatic void model_edge(input logic v, input logic [31:0] d, input logic r, input logic clr);
      bit        acc;
      bit        xfr;
      exp_byte_t e;
      acc = v && (mdl_held < DEPTH);
      xfr = (mdl_held > 0) && r;
      if (xfr) begin
         if (mdl_sent == 3) begin
            mdl_sent = 0;
            mdl_held--;
         end else begin
            mdl_sent++;
         end
      end
      if (acc) begin
         mdl_held++;
         for (int b = 0; b < 4; b++) begin
            e.data = d[8*b +: 8];
            e.last = (b == 3);
            exp_q.push_back(e);
         end
      end
      if (v && !acc) begin
         mdl_ovf  = 1;
         mdl_drop = clr ? 1 : ((mdl_drop < 255) ? mdl_drop + 1 : 255);
      end else if (clr) begin
         mdl_ovf  = 0;
         mdl_drop = 0;
      end
   endfunction

   task automatic step(input logic v, input logic [31:0] d, input logic r, input logic clr);
      bus.in_valid   = v;
      bus.in_data    = d;
      bus.byte_ready = r;
      ovf_clr        = clr;
      @(posedge clk);
      model_edge(v, d, r, clr);
      #2;
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, r, 1'b0);
   endtask

   // Monitor: mid-cycle status compare, stall stability, and scoreboard pops on transfers.
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = '0;
   logic       prev_last  = 1'b0;
   exp_byte_t  got;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         chk("byte_valid", 32'(bus.byte_valid), 32'(mdl_held > 0));
         chk("buf_count", 32'(buf_count), 32'(mdl_held));
         chk("buf_full", 32'(buf_full), 32'(mdl_held == DEPTH));
         chk("overflow", 32'(overflow), 32'(mdl_ovf));
         chk("drop_cnt", 32'(drop_cnt), 32'(mdl_drop));
         if (!bus.byte_valid) chk("last_idle", 32'(bus.byte_last), 32'h0);
         if (prev_stall) begin
            chk("stall_data", 32'(bus.byte_data), 32'(prev_data));
            chk("stall_last", 32'(bus.byte_last), 32'(prev_last));
         end
         if (bus.byte_valid && bus.byte_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", 32'(bus.byte_data), 32'hFFFF_FFFF);
            end else begin
               got = exp_q.pop_front();
               chk("byte_data", 32'(bus.byte_data), 32'(got.data));
               chk("byte_last", 32'(bus.byte_last), 32'(got.last));
            end
         end
         prev_stall = bus.byte_valid && !bus.byte_ready;
         prev_data  = bus.byte_data;
         prev_last  = bus.byte_last;
      end
   end

   initial begin
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.byte_ready = 1'b0;
      ovf_clr        = 1'b0;
      #3;
      chk("rst_valid", 32'(bus.byte_valid), 32'h0);
      chk("rst_data", 32'(bus.byte_data), 32'h0);
      chk("rst_last", 32'(bus.byte_last), 32'h0);
      chk("rst_count", 32'(buf_count), 32'h0);
      chk("rst_full", 32'(buf_full), 32'h0);
      chk("rst_ovf", 32'(overflow), 32'h0);
      chk("rst_drop", 32'(drop_cnt), 32'h0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      idle(2, 1'b1);

      // Single word, sink always ready.
      step(1'b1, 32'hA1B2C3D4, 1'b1, 1'b0);
      idle(6, 1'b1);

      // Backpressure on byte 1.
      step(1'b1, 32'hA1B2C3D4, 1'b1, 1'b0);
      idle(1, 1'b1);
      chk("bp_byte1", 32'(bus.byte_data), 32'hC3);
      idle(3, 1'b0);
      idle(5, 1'b1);

      // Overflow: six words into a stalled sink.
      for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0, 1'b0);
      chk("ovf_count", 32'(buf_count), 32'd4);
      chk("ovf_full", 32'(buf_full), 32'h1);
      chk("ovf_flag", 32'(overflow), 32'h1);
      chk("ovf_drop", 32'(drop_cnt), 32'd2);
      idle(2, 1'b0);
      idle(20, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b1);

      // Full buffer, pop and in_valid on the same edge.
      for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0);
      idle(3, 1'b1);
      step(1'b1, $urandom, 1'b1, 1'b0);
      chk("bnd_count", 32'(buf_count), 32'd3);
      chk("bnd_drop", 32'(drop_cnt), 32'd1);
      step(1'b1, $urandom, 1'b0, 1'b0);
      step(1'b1, $urandom, 1'b0, 1'b1);
      chk("clr_drop_wins", 32'(drop_cnt), 32'd1);
      for (int i = 0; i < 260; i++) step(1'b1, $urandom, 1'b0, 1'b0);
      chk("drop_sat", 32'(drop_cnt), 32'd255);
      step(1'b0, 32'h0, 1'b1, 1'b1);
      idle(20, 1'b1);

      // Streaming: eight words, one per four cycles, wraps both pointers.
      for (int w = 0; w < 8; w++) begin
         step(1'b1, $urandom, 1'b1, 1'b0);
         idle(3, 1'b1);
      end
      idle(4, 1'b1);
      chk("stream_idle", 32'(bus.byte_valid), 32'h0);
      chk("stream_nodrop", 32'(drop_cnt), 32'h0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 3) == 0), $urandom,
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
      end
      idle(40, 1'b1);

      // Reset asserted after byte 1 of a word.
      step(1'b0, 32'h0, 1'b1, 1'b1);
      step(1'b1, 32'h5566_7788, 1'b1, 1'b0);
      idle(2, 1'b1);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_valid", 32'(bus.byte_valid), 32'h0);
      chk("mid_rst_data", 32'(bus.byte_data), 32'h0);
      chk("mid_rst_last", 32'(bus.byte_last), 32'h0);
      chk("mid_rst_count", 32'(buf_count), 32'h0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      step(1'b1, 32'h0BAD_F00D, 1'b1, 1'b0);
      chk("post_rst_byte0", 32'(bus.byte_data), 32'h0D);
      idle(8, 1'b1);

      chk("end_queue_empty", 32'(exp_q.size()), 32'h0);
      chk("end_idle", 32'(bus.byte_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
